// File: rtl/draw_layer_scheduler.sv
// Four-layer priority scheduler for the VGA drawing path with a shadow priority table committed at frame start.
// Optional per-layer blinking is built only when LAYER_BLINK_EN is defined.
module draw_layer_scheduler #(
  parameter int unsigned BLINK_FRAMES    = 16,
  parameter logic [7:0]  TRANSPARENT_RGB = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic [3:0] drawRequest,
  input  logic [7:0] RGB0,
  input  logic [7:0] RGB1,
  input  logic [7:0] RGB2,
  input  logic [7:0] RGB3,
  input  logic       cfgWrite,
  input  logic [1:0] cfgSlot,
  input  logic [1:0] cfgLayer,
  input  logic       cfgEnable,
  input  logic       cfgBlink,
  output logic       cfgReady,
  output logic       cfgPending,
  output logic       cfgError,
  output logic       drawRequestOut,
  output logic [7:0] RGBOut,
  output logic [1:0] winnerLayer
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam logic [3:0][1:0] RESET_SLOTS = {2'd3, 2'd2, 2'd1, 2'd0};

  if (BLINK_FRAMES < 2 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be in 2..255");
  end

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic            wr_en;
  logic            commit_ok;
  logic            err;
  logic [3:0][1:0] act_slot;
  logic [3:0][1:0] shd_slot;
  logic [3:0]      act_en;
  logic [3:0]      shd_en;
  logic [3:0]      act_blink;
  logic [3:0]      shd_blink;
  logic            blink_phase;

  // Config FSM: writes are refused only during the single COMMIT cycle
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (cfgWrite) begin
          wr_en      = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        wr_en = cfgWrite;
        if (startOfFrame) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Four distinct 2-bit ids are necessarily a permutation of 0..3
  always_comb begin
    commit_ok = (shd_slot[0] != shd_slot[1]) && (shd_slot[0] != shd_slot[2]) &&
                (shd_slot[0] != shd_slot[3]) && (shd_slot[1] != shd_slot[2]) &&
                (shd_slot[1] != shd_slot[3]) && (shd_slot[2] != shd_slot[3]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_slot  <= RESET_SLOTS;
      shd_slot  <= RESET_SLOTS;
      act_en    <= 4'hF;
      shd_en    <= 4'hF;
      act_blink <= 4'h0;
      shd_blink <= 4'h0;
      err       <= 1'b0;
    end else if (state == COMMIT) begin
      if (commit_ok) begin
        act_slot  <= shd_slot;
        act_en    <= shd_en;
        act_blink <= shd_blink;
        err       <= 1'b0;
      end else begin
        shd_slot  <= act_slot;
        shd_en    <= act_en;
        shd_blink <= act_blink;
        err       <= 1'b1;
      end
    end else if (wr_en) begin
      shd_slot[cfgSlot]   <= cfgLayer;
      shd_en[cfgLayer]    <= cfgEnable;
      shd_blink[cfgLayer] <= cfgBlink;
    end
  end

  assign cfgReady   = (state != COMMIT);
  assign cfgPending = (state == PENDING);
  assign cfgError   = err;

`ifdef LAYER_BLINK_EN
  logic [7:0] frame_cnt;

  // Phase flips when the frame counter wraps; the pulse cycle itself still sees the old phase
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

  logic [3:0][7:0] rgb;
  logic [3:0]      opaque;
  logic [3:0]      eligible;
  logic            win_req;
  logic [7:0]      win_rgb;
  logic [1:0]      win_layer;

  assign rgb = {RGB3, RGB2, RGB1, RGB0};

  always_comb begin
    opaque = 4'h0;
    for (int l = 0; l < 4; l++) opaque[l] = (rgb[l] != TRANSPARENT_RGB);
  end

  assign eligible = drawRequest & act_en & opaque & ~(act_blink & {4{blink_phase}});

  // Scan from lowest priority upward so the lowest eligible slot overwrites last
  always_comb begin
    win_req   = 1'b0;
    win_rgb   = 8'h00;
    win_layer = 2'd0;
    for (int s = 3; s >= 0; s--) begin
      if (eligible[act_slot[s]]) begin
        win_req   = 1'b1;
        win_rgb   = rgb[act_slot[s]];
        win_layer = act_slot[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drawRequestOut <= 1'b0;
      RGBOut         <= 8'h00;
      winnerLayer    <= 2'd0;
    end else begin
      drawRequestOut <= win_req;
      RGBOut         <= win_rgb;
      winnerLayer    <= win_layer;
    end
  end

endmodule
